// File: rtl/seq_pkg.sv
// Shared constants and types for the 8-byte sequence generator/checker pair.
//   SEQ_LEN    : period of the sequence
//   SEQ_BYTE   : sequence table, index 0..7 (AF BC E2 78 FF E2 0B 8D)
//   SEQ_AMBIG  : the one value that appears twice in the table (index 2 and 5)
//   seq_state_e: checker FSM states
package seq_pkg;
  localparam int SEQ_LEN = 8;

  localparam logic [0:SEQ_LEN-1][7:0] SEQ_BYTE = {
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  localparam logic [7:0] SEQ_AMBIG = 8'hE2;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } seq_state_e;

  function automatic logic [7:0] seq_expected(input logic [2:0] idx);
    return SEQ_BYTE[idx];
  endfunction
endpackage

// File: rtl/seq_index_lookup.sv
// Combinational reverse map from a received byte to its position in the
// sequence table.
//   i_data    in  8  byte to look up
//   o_member  out 1  byte appears somewhere in the table
//   o_unique  out 1  byte appears exactly once (everything except SEQ_AMBIG)
//   o_index   out 3  table position; only meaningful when o_unique=1
module seq_index_lookup
  import seq_pkg::*;
(
  input  logic [7:0] i_data,
  output logic       o_member,
  output logic       o_unique,
  output logic [2:0] o_index
);
  always_comb begin
    o_member = 1'b0;
    o_index  = 3'd0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i_data == SEQ_BYTE[i]) begin
        o_member = 1'b1;
        o_index  = 3'(i);
      end
    end
    // The ambiguous value cannot tell us the phase, so it never seeds alignment.
    o_unique = o_member && (i_data != SEQ_AMBIG);
  end
endmodule

// File: rtl/sequence_checker.sv
// Receive-side checker for the 8-byte sequence generator. Hunts for
// alignment on a uniquely identifiable byte, verifies LOCK_COUNT consecutive
// bytes, then flywheels through the sequence reporting per-byte match/error.
//   clk, reset_n  clock / async active-low reset
//   valid, data   byte stream (sampled only when valid=1)
//   clear_err     synchronous clear of err_count
//   locked        FSM is in LOCKED
//   match_pulse   locked byte matched
//   error_pulse   locked byte mismatched
//   seq_wrap      locked byte at index 7 matched
//   exp_index     index of the next expected byte
//   err_count     saturating count of locked mismatches
module sequence_checker
  import seq_pkg::*;
#(
  parameter int LOCK_COUNT  = 3,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid,
  input  logic [7:0]           data,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 match_pulse,
  output logic                 error_pulse,
  output logic                 seq_wrap,
  output logic [2:0]           exp_index,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic [3:0] UE = 4'(UNLOCK_ERRS);
  localparam seq_state_e SEED_STATE = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;

  seq_state_e           r_state;
  logic [2:0]           r_exp_index;
  logic [2:0]           r_match_cnt;
  logic [2:0]           r_miss_cnt;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 r_locked;
  logic                 r_match_pulse;
  logic                 r_error_pulse;
  logic                 r_seq_wrap;

  logic                 w_member;
  logic                 w_unique;
  logic [2:0]           w_index;
  logic                 w_seed;
  logic                 w_exp_hit;
  logic [3:0]           w_match_nxt;
  logic [3:0]           w_miss_nxt;
  logic [ERR_CNT_W-1:0] w_err_base;
  logic [ERR_CNT_W-1:0] w_err_inc;

  seq_index_lookup u_lookup (
    .i_data   (data),
    .o_member (w_member),
    .o_unique (w_unique),
    .o_index  (w_index)
  );

  assign w_seed      = w_member & w_unique;
  assign w_exp_hit   = (data == seq_expected(r_exp_index));
  assign w_match_nxt = {1'b0, r_match_cnt} + 4'd1;
  assign w_miss_nxt  = {1'b0, r_miss_cnt} + 4'd1;
  // Clear takes effect before the increment, so clear+error yields 1.
  assign w_err_base  = clear_err ? '0 : r_err_count;
  assign w_err_inc   = (&w_err_base) ? w_err_base : w_err_base + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_HUNT;
      r_exp_index   <= 3'd0;
      r_match_cnt   <= 3'd0;
      r_miss_cnt    <= 3'd0;
      r_err_count   <= '0;
      r_locked      <= 1'b0;
      r_match_pulse <= 1'b0;
      r_error_pulse <= 1'b0;
      r_seq_wrap    <= 1'b0;
    end else begin
      r_match_pulse <= 1'b0;
      r_error_pulse <= 1'b0;
      r_seq_wrap    <= 1'b0;
      if (clear_err) r_err_count <= '0;

      if (valid) begin
        case (r_state)
          ST_HUNT: begin
            if (w_seed) begin
              r_exp_index <= w_index + 3'd1;
              r_match_cnt <= 3'd1;
              r_miss_cnt  <= 3'd0;
              r_state     <= SEED_STATE;
              r_locked    <= (SEED_STATE == ST_LOCKED);
            end
          end

          ST_VERIFY: begin
            if (w_exp_hit) begin
              r_exp_index <= r_exp_index + 3'd1;
              r_match_cnt <= w_match_nxt[2:0];
              if (w_match_nxt >= LC) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_miss_cnt <= 3'd0;
              end
            end else if (w_seed) begin
              // Mismatching byte is re-hunted in the same cycle.
              r_exp_index <= w_index + 3'd1;
              r_match_cnt <= 3'd1;
              r_miss_cnt  <= 3'd0;
              r_state     <= SEED_STATE;
              r_locked    <= (SEED_STATE == ST_LOCKED);
            end else begin
              r_state <= ST_HUNT;
            end
          end

          ST_LOCKED: begin
            // Flywheel: phase advances regardless of the byte's content.
            r_exp_index <= r_exp_index + 3'd1;
            if (w_exp_hit) begin
              r_match_pulse <= 1'b1;
              r_seq_wrap    <= (r_exp_index == 3'd7);
              r_miss_cnt    <= 3'd0;
            end else begin
              r_error_pulse <= 1'b1;
              r_err_count   <= w_err_inc;
              r_miss_cnt    <= w_miss_nxt[2:0];
              if (w_miss_nxt >= UE) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
              end
            end
          end

          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked      = r_locked;
  assign match_pulse = r_match_pulse;
  assign error_pulse = r_error_pulse;
  assign seq_wrap    = r_seq_wrap;
  assign exp_index   = r_exp_index;
  assign err_count   = r_err_count;
endmodule

// File: tb/tb_sequence_checker.sv
module tb_sequence_checker;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        clear_err = 1'b0;

  logic        a_locked, a_mp, a_ep, a_sw;
  logic [2:0]  a_exp;
  logic [15:0] a_err;
  logic        b_locked, b_mp, b_ep, b_sw;
  logic [2:0]  b_exp;
  logic [1:0]  b_err;

  always #5 clk = ~clk;

  sequence_checker #(.LOCK_COUNT(3), .UNLOCK_ERRS(2), .ERR_CNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n), .valid(valid), .data(data), .clear_err(clear_err),
    .locked(a_locked), .match_pulse(a_mp), .error_pulse(a_ep), .seq_wrap(a_sw),
    .exp_index(a_exp), .err_count(a_err));

  sequence_checker #(.LOCK_COUNT(3), .UNLOCK_ERRS(2), .ERR_CNT_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .valid(valid), .data(data), .clear_err(clear_err),
    .locked(b_locked), .match_pulse(b_mp), .error_pulse(b_ep), .seq_wrap(b_sw),
    .exp_index(b_exp), .err_count(b_err));

  bit [7:0] TBL [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  typedef struct {
    bit locked, mp, ep, sw;
    int exp, err16, err2;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  // Reference model: acquisition phase as a small integer, counts as ints.
  int m_phase;   // 0 searching, 1 confirming, 2 locked
  int m_exp, m_good, m_bad, m_err16, m_err2;
  int pos = 0;   // generator position

  function automatic int find_idx(input bit [7:0] d);
    int cnt = 0;
    int idx = -1;
    for (int i = 0; i < 8; i++) if (TBL[i] == d) begin cnt++; idx = i; end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic m_reset();
    exp_t e;
    m_phase = 0; m_exp = 0; m_good = 0; m_bad = 0; m_err16 = 0; m_err2 = 0;
    e = '{0, 0, 0, 0, 0, 0, 0};
    q.push_back(e);
  endtask

  task automatic m_step(input bit v, input bit [7:0] d, input bit clr);
    exp_t e;
    int i;
    e = '{0, 0, 0, 0, 0, 0, 0};
    if (clr) begin m_err16 = 0; m_err2 = 0; end
    if (v) begin
      if (m_phase == 1 && d == TBL[m_exp]) begin
        m_exp = (m_exp + 1) % 8;
        m_good++;
        if (m_good >= 3) begin m_phase = 2; m_bad = 0; end
      end else if (m_phase == 2) begin
        if (d == TBL[m_exp]) begin
          e.mp = 1; e.sw = (m_exp == 7); m_bad = 0;
        end else begin
          e.ep = 1;
          m_err16 = (m_err16 < 65535) ? m_err16 + 1 : 65535;
          m_err2  = (m_err2 < 3) ? m_err2 + 1 : 3;
          m_bad++;
          if (m_bad >= 2) m_phase = 0;
        end
        m_exp = (m_exp + 1) % 8;
      end else begin
        i = find_idx(d);
        if (i >= 0) begin m_exp = (i + 1) % 8; m_good = 1; m_phase = 1; end
        else m_phase = 0;
      end
    end
    e.locked = (m_phase == 2);
    e.exp = m_exp; e.err16 = m_err16; e.err2 = m_err2;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, expv);
    end
  endtask

  // Monitor: one expected entry per cycle, compared after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("locked",    int'(a_locked), int'(e.locked));
      chk("match",     int'(a_mp),     int'(e.mp));
      chk("error",     int'(a_ep),     int'(e.ep));
      chk("wrap",      int'(a_sw),     int'(e.sw));
      chk("exp_index", int'(a_exp),    e.exp);
      chk("err16",     int'(a_err),    e.err16);
      chk("b_locked",  int'(b_locked), int'(e.locked));
      chk("b_match",   int'(b_mp),     int'(e.mp));
      chk("b_error",   int'(b_ep),     int'(e.ep));
      chk("b_wrap",    int'(b_sw),     int'(e.sw));
      chk("b_exp",     int'(b_exp),    e.exp);
      chk("err2",      int'(b_err),    e.err2);
    end
  end

  task automatic cyc(input bit v, input bit [7:0] d, input bit clr);
    @(negedge clk);
    reset_n = 1'b1; valid = v; data = d; clear_err = clr;
    m_step(v, d, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; valid = 1'b0; clear_err = 1'b0;
    m_reset();
  endtask

  task automatic gen(input int n);
    repeat (n) begin cyc(1'b1, TBL[pos], 1'b0); pos = (pos + 1) % 8; end
  endtask

  task automatic bad(input bit clr);
    cyc(1'b1, 8'h00, clr); pos = (pos + 1) % 8;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // 1) aligned start
    do_reset(); pos = 0; gen(16);
    // 2) start on ambiguous E2
    do_reset(); pos = 2; gen(12);
    // 3) single corruption
    while (pos != 4) gen(1);
    bad(1'b0); gen(3);
    // 4) double corruption, lose lock, relock
    bad(1'b0); bad(1'b0); gen(3);
    while (pos != 0) gen(1);
    gen(8);
    // 5) valid gaps
    idle(5); gen(3);
    repeat (8) begin gen(1); idle(1); end
    // 6) saturating count, clear with error, clear while idle
    do_reset(); pos = 0; gen(4);
    repeat (5) begin bad(1'b0); gen(2); end
    bad(1'b1); gen(2);
    cyc(1'b0, 8'h00, 1'b1); gen(3);
    // random phase
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 999);
      if (r < 3) do_reset();
      else if (r < 10) pos = $urandom_range(0, 7);
      else if ($urandom_range(0, 3) == 0) idle(1);
      else if ($urandom_range(0, 15) == 0) begin
        cyc(1'b1, 8'($urandom), ($urandom_range(0, 63) == 0)); pos = (pos + 1) % 8;
      end else begin
        cyc(1'b1, TBL[pos], ($urandom_range(0, 63) == 0)); pos = (pos + 1) % 8;
      end
    end
    idle(3);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
